// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with registered grant index, decoded one-hot grant
// and a hold watchdog that forces release after TIMEOUT cycles.
module rr_arbiter16 #(
   parameter int unsigned TIMEOUT = 32,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   input  logic        done,
   output logic [15:0] grant,
   output logic [3:0]  grant_idx,
   output logic        grant_valid,
   output logic        timeout
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e             state_q, state_d;
   logic [3:0]         ptr_q, ptr_d;
   logic [3:0]         idx_q, idx_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               timeout_q, timeout_d;

   logic               pick_found;
   logic [3:0]         pick_idx;
   logic [3:0]         scan_idx;
   logic               rel_done, rel_drop, rel_to, release_now;

   // First set request bit scanning upward from ptr, wrapping at 16.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = ptr_q;
      scan_idx   = ptr_q;
      for (int i = 0; i < 16; i++) begin
         scan_idx = ptr_q + 4'(i);
         if (!pick_found && req[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   assign rel_done    = done;
   assign rel_drop    = !req[idx_q];
   assign rel_to      = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
   assign release_now = rel_done || rel_drop || rel_to;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               idx_d   = pick_idx;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (release_now) begin
               valid_d   = 1'b0;
               ptr_d     = idx_q + 4'd1;
               state_d   = StIdle;
               // Flag only releases the watchdog caused on its own.
               timeout_d = rel_to && !rel_done && !rel_drop;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant       = valid_q ? (16'h0001 << idx_q) : 16'h0000;
   assign grant_idx   = idx_q;
   assign grant_valid = valid_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16: vector table for arbitration order, hand sequences for
// rotation, watchdog timing and asynchronous reset.
module tb_rr_arbiter16;

   logic        clk, rst;
   logic [15:0] req, req4;
   logic        done, done4;
   logic [15:0] grant, grant4;
   logic [3:0]  grant_idx, grant_idx4;
   logic        grant_valid, grant_valid4;
   logic        timeout, timeout4;

   int n_checks = 0;
   int n_fail   = 0;

   rr_arbiter16 dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
   );

   rr_arbiter16 #(.TIMEOUT(4), .CNT_W(8)) dut4 (
      .clk(clk), .rst(rst), .req(req4), .done(done4),
      .grant(grant4), .grant_idx(grant_idx4), .grant_valid(grant_valid4), .timeout(timeout4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] req;
      logic        done;
      logic        v;
      logic [3:0]  idx;
      logic        t;
   } vec_t;

   vec_t vecs [0:20];

   function automatic logic [21:0] expw(input logic v, input logic [3:0] idx, input logic t);
      logic [15:0] g;
      g = v ? (16'h0001 << idx) : 16'h0000;
      return {g, idx, v, t};
   endfunction

   task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, want grant=%h idx=%0d valid=%b timeout=%b",
                  name, act[21:6], act[5:2], act[1], act[0], exp[21:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [21:0] act_main();
      return {grant, grant_idx, grant_valid, timeout};
   endfunction

   function automatic logic [21:0] act4();
      return {grant4, grant_idx4, grant_valid4, timeout4};
   endfunction

   initial begin
      //           req       done  v     idx    t
      vecs[0]  = '{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[1]  = '{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[2]  = '{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[3]  = '{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[4]  = '{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[5]  = '{16'h0010, 1'b0, 1'b1, 4'd4,  1'b0};
      vecs[6]  = '{16'h0010, 1'b0, 1'b1, 4'd4,  1'b0};
      vecs[7]  = '{16'h0013, 1'b0, 1'b1, 4'd4,  1'b0};
      vecs[8]  = '{16'h0010, 1'b1, 1'b0, 4'd4,  1'b0};
      vecs[9]  = '{16'h0030, 1'b0, 1'b1, 4'd5,  1'b0};
      vecs[10] = '{16'h0030, 1'b1, 1'b0, 4'd5,  1'b0};
      vecs[11] = '{16'h0001, 1'b0, 1'b1, 4'd0,  1'b0};
      vecs[12] = '{16'h0001, 1'b1, 1'b0, 4'd0,  1'b0};
      vecs[13] = '{16'h8001, 1'b0, 1'b1, 4'd15, 1'b0};
      vecs[14] = '{16'h8001, 1'b1, 1'b0, 4'd15, 1'b0};
      vecs[15] = '{16'h8001, 1'b0, 1'b1, 4'd0,  1'b0};
      vecs[16] = '{16'h8000, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[17] = '{16'h8000, 1'b0, 1'b1, 4'd15, 1'b0};
      vecs[18] = '{16'h8000, 1'b1, 1'b0, 4'd15, 1'b0};
      vecs[19] = '{16'h0000, 1'b1, 1'b0, 4'd15, 1'b0};
      vecs[20] = '{16'h0000, 1'b0, 1'b0, 4'd15, 1'b0};

      rst = 1'b1; req = '0; done = 1'b0; req4 = '0; done4 = 1'b0;
      #12 rst = 1'b0;
      check("reset_state", act_main(), expw(1'b0, 4'd0, 1'b0));

      for (int i = 0; i < 21; i++) begin
         req  = vecs[i].req;
         done = vecs[i].done;
         step();
         check($sformatf("vec%0d", i), act_main(), expw(vecs[i].v, vecs[i].idx, vecs[i].t));
      end

      // ptr is 0 here; all-ones request must rotate 0..15 then wrap to 0.
      for (int k = 0; k <= 16; k++) begin
         req = 16'hFFFF; done = 1'b0;
         step();
         check($sformatf("rot_grant%0d", k), act_main(), expw(1'b1, 4'(k), 1'b0));
         done = 1'b1;
         step();
         check($sformatf("rot_release%0d", k), act_main(), expw(1'b0, 4'(k), 1'b0));
      end
      req = '0; done = 1'b0;

      // Watchdog: grant held 4 cycles, one-cycle timeout pulse, regrant next cycle.
      req4 = 16'h0100; done4 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         check($sformatf("wd_hold%0d", c), act4(), expw(1'b1, 4'd8, 1'b0));
      end
      step();
      check("wd_timeout", act4(), expw(1'b0, 4'd8, 1'b1));
      step();
      check("wd_regrant", act4(), expw(1'b1, 4'd8, 1'b0));
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("wd_hold2_%0d", c), act4(), expw(1'b1, 4'd8, 1'b0));
      end
      done4 = 1'b1;
      step();
      check("wd_done_coincide", act4(), expw(1'b0, 4'd8, 1'b0));
      req4 = '0; done4 = 1'b0;
      step();
      check("wd_idle", act4(), expw(1'b0, 4'd8, 1'b0));

      // Asynchronous reset mid-grant; ptr is 1 so idx 7 is chosen first.
      req = 16'h0080;
      step();
      check("pre_rst_grant7", act_main(), expw(1'b1, 4'd7, 1'b0));
      #2 rst = 1'b1;
      #1;
      check("async_rst", act_main(), expw(1'b0, 4'd0, 1'b0));
      step();
      rst = 1'b0;
      req = 16'h0081;
      step();
      check("post_rst_grant0", act_main(), expw(1'b1, 4'd0, 1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
